// File: rtl/seg7_595_scan_driver.sv
// Continuous scan driver for a 7-seg display behind two chained 74HC595s.
// Define SEG7_RAW_MODE_EN to add the RAW input (bytes sent undecoded).
module seg7_595_scan_driver #(
  parameter int NUM_DIGITS        = 8,
  parameter int CLK_DIV           = 4,
  parameter int LATCH_CYCLES      = 4,
  parameter bit DIGIT_ACTIVE_HIGH = 1'b1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [8*NUM_DIGITS-1:0] DATA,
  input  logic                    LOAD,
`ifdef SEG7_RAW_MODE_EN
  input  logic                    RAW,
`endif
  output logic                    READY,
  output logic                    DIO,
  output logic                    SCK,
  output logic                    RCK,
  output logic                    FRAME
);

  localparam int DW   = 8 * NUM_DIGITS;
  localparam int CMAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATCH_CYCLES - 1);
  localparam logic [2:0]    LAST   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {LOADW, SHL, SHH, LATCH} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_bit, w_bit_nx;
  logic [2:0]    r_digit, w_digit_nx;
  logic [15:0]   r_word, w_word_nx;
  logic [DW-1:0] r_act, r_pend;
  logic          r_pending;
  logic          r_dio, r_sck, r_rck, r_frame;
  logic          w_wrap, w_xfer, w_accept, w_dio_nx;
  logic [7:0]    w_chr, w_seg, w_oh, w_pos;
  logic          r_raw_act, r_raw_pend, w_raw_in;

`ifdef SEG7_RAW_MODE_EN
  assign w_raw_in = RAW;
`else
  assign w_raw_in = 1'b0;
`endif

  function automatic logic [7:0] f_decode(input logic [7:0] c);
    case (c)
      "0", "O":      return 8'hC0;
      "1":           return 8'hF9;
      "2":           return 8'hA4;
      "3":           return 8'hB0;
      "4":           return 8'h99;
      "5", "S", "s": return 8'h92;
      "6":           return 8'h82;
      "7":           return 8'hF8;
      "8":           return 8'h80;
      "9":           return 8'h98;
      "A":           return 8'h88;
      "b", "B":      return 8'h83;
      "C":           return 8'hC6;
      "c":           return 8'hA7;
      "d", "D":      return 8'hA1;
      "E":           return 8'h86;
      "F", "f":      return 8'h8E;
      "H":           return 8'h89;
      "L":           return 8'hC7;
      "n":           return 8'hAB;
      "P":           return 8'h8C;
      "r":           return 8'hAF;
      "t":           return 8'h87;
      "U":           return 8'hC1;
      "-":           return 8'hBF;
      ".":           return 8'h7F;
      default:       return 8'hFF;
    endcase
  endfunction

  // Select the current digit's character and build its segment/position bytes.
  always_comb begin
    w_chr = 8'h20;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_digit == 3'(i)) w_chr = r_act[DW-8-8*i +: 8];
    w_seg = r_raw_act ? w_chr : f_decode(w_chr);
    w_oh  = 8'b1 << r_digit;
    w_pos = DIGIT_ACTIVE_HIGH ? w_oh : ~w_oh;
  end

  // Next-state logic for the shift/latch sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_digit_nx = r_digit;
    w_word_nx  = r_word;
    w_wrap     = 1'b0;
    unique case (r_state)
      LOADW: begin
        w_state_nx = SHL;
        w_cnt_nx   = DIV_M1;
        w_bit_nx   = 4'd15;
        w_word_nx  = {w_pos, w_seg};
      end
      SHL: begin
        if (r_cnt == '0) begin
          w_state_nx = SHH;
          w_cnt_nx   = DIV_M1;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      SHH: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else if (r_bit == 4'd0) begin
          w_state_nx = LATCH;
          w_cnt_nx   = LAT_M1;
        end else begin
          w_state_nx = SHL;
          w_cnt_nx   = DIV_M1;
          w_bit_nx   = r_bit - 1'b1;
        end
      end
      LATCH: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          w_state_nx = LOADW;
          if (r_digit == LAST) begin
            w_digit_nx = 3'd0;
            w_wrap     = 1'b1;
          end else begin
            w_digit_nx = r_digit + 1'b1;
          end
        end
      end
      default: w_state_nx = LOADW;
    endcase
    w_dio_nx = ((w_state_nx == SHL) || (w_state_nx == SHH))
             ? w_word_nx[w_bit_nx] : 1'b0;
  end

  assign w_xfer   = w_wrap && r_pending;
  assign w_accept = LOAD && (!r_pending || w_xfer);

  // Sequencer state and registered pin outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= LOADW;
      r_cnt   <= '0;
      r_bit   <= 4'd15;
      r_digit <= 3'd0;
      r_word  <= '0;
      r_dio   <= 1'b0;
      r_sck   <= 1'b0;
      r_rck   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_digit <= w_digit_nx;
      r_word  <= w_word_nx;
      r_dio   <= w_dio_nx;
      r_sck   <= (w_state_nx == SHH);
      r_rck   <= (w_state_nx == LATCH);
      r_frame <= w_wrap;
    end
  end

  // Double buffer: capture into pending, promote to active at frame wrap.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_act      <= {NUM_DIGITS{8'h20}};
      r_pend     <= {NUM_DIGITS{8'h20}};
      r_pending  <= 1'b0;
      r_raw_act  <= 1'b0;
      r_raw_pend <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_act     <= r_pend;
        r_raw_act <= r_raw_pend;
      end
      if (w_accept) begin
        r_pend     <= DATA;
        r_raw_pend <= w_raw_in;
        r_pending  <= 1'b1;
      end else if (w_xfer) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign READY = !r_pending;
  assign DIO   = r_dio;
  assign SCK   = r_sck;
  assign RCK   = r_rck;
  assign FRAME = r_frame;

endmodule
